// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry layout and flush-walk FSM states.
package rob_pkg;

    localparam int PRD_W = 7;
    localparam int ARD_W = 5;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             has_rd;
        logic [ARD_W-1:0] arch_rd;
        logic [PRD_W-1:0] new_prd;
        logic [PRD_W-1:0] old_prd;
    } rob_entry_t;

    typedef enum logic {
        IDLE,
        WALK
    } rob_state_e;

endpackage

// File: rtl/rob_retire_if.sv
// Rename/execute/retire handshake bundle of the reorder buffer.
// master = rename/execute side, slave = rob_retire.
interface rob_retire_if #(
    parameter int DEPTH = 32,
    parameter int PRD_W = 7,
    parameter int ARD_W = 5
);
    localparam int IW = $clog2(DEPTH);

    logic             alloc_valid;
    logic             alloc_ready;
    logic             alloc_has_rd;
    logic [ARD_W-1:0] alloc_arch_rd;
    logic [PRD_W-1:0] alloc_new_prd;
    logic [PRD_W-1:0] alloc_old_prd;
    logic [IW-1:0]    alloc_idx;
    logic             cmpl_valid;
    logic [IW-1:0]    cmpl_idx;
    logic             free_push;
    logic [PRD_W-1:0] free_prd;
    logic             commit_valid;
    logic [ARD_W-1:0] commit_arch_rd;
    logic [PRD_W-1:0] commit_prd;
    logic             rob_empty;

    modport master (
        output alloc_valid, alloc_has_rd, alloc_arch_rd,
        output alloc_new_prd, alloc_old_prd,
        output cmpl_valid, cmpl_idx,
        input  alloc_ready, alloc_idx,
        input  free_push, free_prd,
        input  commit_valid, commit_arch_rd, commit_prd,
        input  rob_empty
    );

    modport slave (
        input  alloc_valid, alloc_has_rd, alloc_arch_rd,
        input  alloc_new_prd, alloc_old_prd,
        input  cmpl_valid, cmpl_idx,
        output alloc_ready, alloc_idx,
        output free_push, free_prd,
        output commit_valid, commit_arch_rd, commit_prd,
        output rob_empty
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping ROB pointer with increment/decrement enables.
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc && !dec)
            ptr <= ptr + W'(1);
        else if (dec && !inc)
            ptr <= ptr - W'(1);
    end

endmodule

// File: rtl/rob_retire.sv
// In-order retirement ROB feeding superseded physical registers back to free_list.
// ROB_FLUSH_EN adds flush/flush_busy and a tail-walk squash FSM.
module rob_retire
    import rob_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int PRD_W = rob_pkg::PRD_W,
    parameter int ARD_W = rob_pkg::ARD_W
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ROB_FLUSH_EN
    input  logic       flush,
    output logic       flush_busy,
`endif
    rob_retire_if.slave rob
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    rob_entry_t       ent [DEPTH];
    rob_entry_t       h_ent;
    logic [IW-1:0]    head;
    logic [IW-1:0]    tail;
    logic [IW-1:0]    tail_m1;
    logic [CW-1:0]    count;
    logic             busy;
    logic             flush_go;
    logic             walk;
    logic             do_alloc;
    logic             do_cmpl;
    logic             ret;
    logic             fp;
    logic [PRD_W-1:0] fprd;
    logic [PRD_W-1:0] cprd;
    logic [ARD_W-1:0] carch;

`ifdef ROB_FLUSH_EN
    rob_state_e state;
    rob_state_e state_nx;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        flush_go = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush && count != '0) begin
                    flush_go = 1'b1;
                    state_nx = WALK;
                end
            end
            WALK: begin
                if (count == CW'(1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state == WALK);
    assign flush_busy = busy;
`else
    assign busy     = 1'b0;
    assign flush_go = 1'b0;
`endif

    assign walk    = busy;
    assign tail_m1 = tail - IW'(1);
    assign h_ent   = ent[head];

    // A flush accepted this cycle blocks every other state change.
    assign rob.alloc_ready = (count != CW'(DEPTH)) && !busy && !flush_go;
    assign do_alloc = rob.alloc_valid && rob.alloc_ready;
    assign ret      = h_ent.valid && h_ent.done && !busy && !flush_go;
    assign do_cmpl  = rob.cmpl_valid && ent[rob.cmpl_idx].valid
                      && !busy && !flush_go;

    rob_ptr #(.W(IW)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (ret),
        .dec (1'b0),
        .ptr (head)
    );

    rob_ptr #(.W(IW)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (do_alloc),
        .dec (walk),
        .ptr (tail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done  <= 1'b0;
            end
        end else begin
            if (do_cmpl)
                ent[rob.cmpl_idx].done <= 1'b1;
            if (ret)
                ent[head].valid <= 1'b0;
            if (walk) begin
                ent[tail_m1].valid <= 1'b0;
                ent[tail_m1].done  <= 1'b0;
            end
            if (do_alloc) begin
                ent[tail].valid   <= 1'b1;
                ent[tail].done    <= 1'b0;
                ent[tail].has_rd  <= rob.alloc_has_rd;
                ent[tail].arch_rd <= rob.alloc_arch_rd;
                ent[tail].new_prd <= rob.alloc_new_prd;
                ent[tail].old_prd <= rob.alloc_old_prd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count + CW'(do_alloc) - CW'(ret) - CW'(walk);
    end

    // Squash walk frees the youngest new mapping; retire frees the old one.
    always_comb begin
        fp    = ret && h_ent.has_rd;
        fprd  = h_ent.old_prd;
        cprd  = h_ent.new_prd;
        carch = h_ent.arch_rd;
        if (walk) begin
            fp   = ent[tail_m1].has_rd;
            fprd = ent[tail_m1].new_prd;
        end
    end

    assign rob.alloc_idx      = tail;
    assign rob.commit_valid   = ret;
    assign rob.commit_arch_rd = carch;
    assign rob.commit_prd     = cprd;
    assign rob.free_push      = fp;
    assign rob.free_prd       = fprd;
    assign rob.rob_empty      = (count == '0);

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer that records each renamed instruction's new and previous physical destination and retires instructions in program order. At retirement it returns the superseded physical register to `free_list` on its push side and reports the architectural commit. This is the release end of the rename/free-list loop: `free_list` hands out registers at rename, and `rob_retire` hands them back.

## Interface
**Parameters**
- `DEPTH`, default 32: ROB entries. Must be a power of 2, 4..64.
- `PRD_W`, default 7: physical register index width. Must match `free_list`.
- `ARD_W`, default 5: architectural register index width.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `alloc_valid`, in, 1: rename requests an entry.
- `alloc_ready`, out, 1: an entry is accepted this cycle.
- `alloc_has_rd`, in, 1: the instruction writes a destination register.
- `alloc_arch_rd`, in, ARD_W: architectural destination.
- `alloc_new_prd`, in, PRD_W: newly popped physical register.
- `alloc_old_prd`, in, PRD_W: previous mapping of `alloc_arch_rd`.
- `alloc_idx`, out, $clog2(DEPTH): index assigned to the request (the tail pointer).
- `cmpl_valid`, in, 1: execution complete.
- `cmpl_idx`, in, $clog2(DEPTH): ROB index that completed.
- `free_push`, out, 1: connects to `free_list.push`.
- `free_prd`, out, PRD_W: connects to `free_list.push_rd`.
- `commit_valid`, out, 1: head instruction retires this cycle.
- `commit_arch_rd`, out, ARD_W: architectural destination of the retiring instruction.
- `commit_prd`, out, PRD_W: physical destination of the retiring instruction.
- `rob_empty`, out, 1: count == 0.
- `flush`, in, 1: present only with `ROB_FLUSH_EN`.
- `flush_busy`, out, 1: present only with `ROB_FLUSH_EN`.

## Operation
**State**
- `head`, `tail`: $clog2(DEPTH) bits, natural wrap.
- `count`: $clog2(DEPTH)+1 bits.
- Per entry: `valid`, `done`, `has_rd`, `arch_rd`, `new_prd`, `old_prd`.

**Allocate**
- `alloc_ready = (count != DEPTH) && !flush_busy`.
- On `alloc_valid && alloc_ready`: write the entry at `tail` with `valid=1`, `done=0`; increment `tail`.

**Complete**
- `cmpl_valid` sets `done` at `cmpl_idx` if that entry is valid; otherwise it is ignored.
- A completion to the entry being allocated in the same cycle is illegal.

**Retire** (combinational from registered state)
- Condition: `ret = valid[head] && done[head] && !flush_busy`.
- `commit_valid = ret`, with `commit_arch_rd` / `commit_prd` taken from the head entry's `arch_rd` / `new_prd`.
- `free_push = ret && has_rd[head]`, with `free_prd = old_prd[head]`.
- On `ret`: clear `valid[head]` and increment `head`.

**Count update**
- `count` changes by +alloc −ret.
- Simultaneous alloc and retire leaves `count` unchanged.

**Boundaries**
- When full, `alloc_ready=0` even if a retire occurs in the same cycle.
- When empty, no retire.
- Pointers wrap from DEPTH−1 to 0 without a bubble.

**Reset**
- `head=tail=count=0`, all `valid` and `done` cleared.
- Outputs: `free_push=0`, `commit_valid=0`, `alloc_ready=1`, `rob_empty=1`, `flush_busy=0`.
- Reset mid-flush returns to IDLE and all walk state is dropped.

## Timing
- Alloc at edge N → entry is valid from N+1; `alloc_idx` is valid in the same cycle as the request.
- Complete at edge M → `commit_valid` can assert in cycle M+1. The earliest retire is 2 cycles after allocation.
- Retire throughput: at most 1 per cycle.
- `free_push` is combinational and is sampled by `free_list` at the next edge.

## Configuration
**`ROB_FLUSH_EN` defined**
- Adds the `flush` input, the `flush_busy` output, and a two-state FSM (IDLE, WALK).
- `flush` in IDLE with count > 0 → WALK. `flush` with count == 0 has no effect.
- In WALK, each cycle:
  - `tail` steps back by 1 and `count` decrements.
  - If the squashed entry has `has_rd`, `free_push=1` with `free_prd = new_prd` of that entry.
  - The entry is invalidated.
  - When `count` reaches 0 → IDLE.
- `flush_busy = (state == WALK)`.
- During WALK: alloc blocked, retire suppressed, `cmpl_valid` ignored.
- `flush` has priority over alloc, complete and retire in the same cycle, and is ignored while in WALK.

**Not defined**
- No flush port and no FSM. `flush_busy` is treated as constant 0.

## Structure
- Package `rob_pkg`: `PRD_W`, `ARD_W` defaults, `rob_entry_t` packed struct (`valid`, `done`, `has_rd`, `arch_rd`, `new_prd`, `old_prd`), `rob_state_e` {IDLE, WALK}.
- One sub-module, `rob_ptr`: wrapping pointer with increment/decrement enables and synchronous reset to 0, instantiated for `head` and `tail`.

## Test plan
- Reset → `alloc_ready=1`, `rob_empty=1`, `free_push=0`, `commit_valid=0`.
- Alloc idx0 (arch 3, new 40, old 3) then complete idx0 → next cycle `commit_valid=1`, `commit_arch_rd=3`, `commit_prd=40`, `free_push=1`, `free_prd=3`.
- Alloc 0,1,2; complete 2 then 1 then 0 → retires in order 0,1,2 on consecutive cycles, after idx0 completes.
- Fill to 32 → `alloc_ready=0`; retire one while `alloc_valid` high → no accept that cycle, accept next; `tail` wraps to 0.
- `alloc_has_rd=0` entry retires → `commit_valid=1`, `free_push=0`.
- `ROB_FLUSH_EN`: 3 entries with new_prd 50,51,52 and `flush` → `flush_busy` for 3 cycles, `free_prd` 52,51,50, then `rob_empty=1`.
